// File: rtl/occupancy_pkg.sv
// Shared types for the multi-lane occupancy counter: lane FSM state
// encoding, state width, and the per-lane completion event record.
package occupancy_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_AB = 3'd5,
    EX_A  = 3'd6
  } lane_state_t;

  typedef struct packed {
    logic entry;
    logic exit;
  } lane_event_t;

endpackage

// File: rtl/occupancy_lane_fsm.sv
// Per-lane beam sequence recogniser. Outer beam a, inner beam b.
// A->AB->B->clear is an entry; B->AB->A->clear is an exit. Partial
// passages that clear early are dropped. entry_now/exit_now flag the
// completing cycle combinationally so the shared counter can update on
// the same edge as the registered pulses.
module occupancy_lane_fsm
  import occupancy_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a,
  input  logic            b,
  output logic [ST_W-1:0] state,
  output logic            entry_now,
  output logic            exit_now,
  output logic            entry_pulse,
  output logic            exit_pulse
);

  lane_state_t state_q;

  assign entry_now = (state_q == EN_B) && !a && !b;
  assign exit_now  = (state_q == EX_A) && !a && !b;
  assign state     = state_q;

  // Sequence FSM plus one-cycle completion pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments on all flops so every register
      // samples pre-edge values regardless of statement order.
      entry_pulse <= entry_now;
      exit_pulse  <= exit_now;
      case (state_q)
        IDLE: begin
          if (a && !b)      state_q <= EN_A;
          else if (!a && b) state_q <= EX_B;
        end
        EN_A: begin
          if (a && b)        state_q <= EN_AB;
          else if (!a && !b) state_q <= IDLE;
        end
        EN_AB: begin
          if (!a && b)       state_q <= EN_B;
          else if (a && !b)  state_q <= EN_A;
          else if (!a && !b) state_q <= IDLE;
        end
        EN_B: begin
          if (!a && !b)     state_q <= IDLE;
          else if (a && b)  state_q <= EN_AB;
        end
        EX_B: begin
          if (a && b)        state_q <= EX_AB;
          else if (!a && !b) state_q <= IDLE;
        end
        EX_AB: begin
          if (a && !b)       state_q <= EX_A;
          else if (!a && b)  state_q <= EX_B;
          else if (!a && !b) state_q <= IDLE;
        end
        EX_A: begin
          if (!a && !b)     state_q <= IDLE;
          else if (a && b)  state_q <= EX_AB;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/occupancy_counter.sv
// Multi-lane occupancy counter. One sequence FSM per lane; completions
// from all lanes are netted and applied to a single count saturating at
// [0, CAPACITY], with sticky overflow/underflow flags and a synchronous
// clear. Define OCC_SYNC_EN to insert a 2-flop synchroniser on every
// sensor input (adds 2 cycles of sensor-to-output latency).
module occupancy_counter
  import occupancy_pkg::*;
#(
  parameter  int NUM_LANES = 2,
  parameter  int CAPACITY  = 15,
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clr,
  input  logic [NUM_LANES-1:0]      sens_a,
  input  logic [NUM_LANES-1:0]      sens_b,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic [NUM_LANES-1:0]      entry_pulse,
  output logic [NUM_LANES-1:0]      exit_pulse,
  output logic                      ovf_err,
  output logic                      unf_err,
  output logic [ST_W*NUM_LANES-1:0] debug_state
);

  // Delta is wide enough for +/-NUM_LANES; the sum adds headroom for
  // both the count range and a negative residual.
  localparam int DW = $clog2(NUM_LANES) + 2;
  localparam int SW = CNT_W + DW + 1;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

  logic [NUM_LANES-1:0] a_in, b_in;
  logic [NUM_LANES-1:0] entry_now, exit_now;
  lane_event_t          lane_evt [NUM_LANES];

`ifdef OCC_SYNC_EN
  logic [NUM_LANES-1:0] a_s1, a_s2, b_s1, b_s2;

  // Two-stage synchronisers on the raw beam inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s1 <= '0;
      a_s2 <= '0;
      b_s1 <= '0;
      b_s2 <= '0;
    end else begin
      a_s1 <= sens_a;
      a_s2 <= a_s1;
      b_s1 <= sens_b;
      b_s2 <= b_s1;
    end
  end

  assign a_in = a_s2;
  assign b_in = b_s2;
`else
  assign a_in = sens_a;
  assign b_in = sens_b;
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    occupancy_lane_fsm u_fsm (
      .clk         (clk),
      .reset_n     (reset_n),
      .a           (a_in[i]),
      .b           (b_in[i]),
      .state       (debug_state[ST_W*i +: ST_W]),
      .entry_now   (entry_now[i]),
      .exit_now    (exit_now[i]),
      .entry_pulse (entry_pulse[i]),
      .exit_pulse  (exit_pulse[i])
    );
    assign lane_evt[i] = {entry_now[i], exit_now[i]};
  end

  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q, unf_q, ovf_hit, unf_hit;
  logic [DW-1:0]           n_ent, n_ex;
  logic signed [DW-1:0]    delta;
  logic signed [SW-1:0]    sum;

  // Net this cycle's completions, then clamp only the residual.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    n_ent   = '0;
    n_ex    = '0;
    ovf_hit = 1'b0;
    unf_hit = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_ent = n_ent + DW'(lane_evt[i].entry);
      n_ex  = n_ex  + DW'(lane_evt[i].exit);
    end
    delta   = $signed(n_ent) - $signed(n_ex);
    sum     = $signed({{(SW-CNT_W){1'b0}}, count_q})
            + $signed({{(SW-DW){delta[DW-1]}}, delta});
    count_d = sum[CNT_W-1:0];
    if (sum < 0) begin
      count_d = '0;
      unf_hit = 1'b1;
    end else if (sum > CAP_S) begin
      count_d = CNT_W'(CAPACITY);
      ovf_hit = 1'b1;
    end
  end

  // Count and sticky error flags; clear wins over any same-cycle event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (ovf_hit) ovf_q <= 1'b1;
      if (unf_hit) unf_q <= 1'b1;
    end
  end

  assign count   = count_q;
  assign full    = (count_q == CNT_W'(CAPACITY));
  assign empty   = (count_q == '0);
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Scoreboard bench for occupancy_counter (NUM_LANES=2, CAPACITY=15).
// A behavioural model predicts every output per cycle; predictions are
// queued when stimulus is driven and compared after the next edge.
module tb_occupancy_counter;

  localparam int NL  = 2;
  localparam int CAP = 15;
`ifdef OCC_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr;
  logic [NL-1:0] sens_a, sens_b;
  logic [3:0]    count;
  logic          full, empty, ovf_err, unf_err;
  logic [NL-1:0] entry_pulse, exit_pulse;
  logic [3*NL-1:0] debug_state;

  occupancy_counter #(.NUM_LANES(NL), .CAPACITY(CAP)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clr         (clr),
    .sens_a      (sens_a),
    .sens_b      (sens_b),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .entry_pulse (entry_pulse),
    .exit_pulse  (exit_pulse),
    .ovf_err     (ovf_err),
    .unf_err     (unf_err),
    .debug_state (debug_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cnt;
    logic [NL-1:0] ent;
    logic [NL-1:0] ex;
    logic          ovf;
    logic          unf;
    logic [3*NL-1:0] dbg;
  } exp_t;

  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int            m_state [NL];
  int            m_cnt;
  logic          m_ovf, m_unf;
  logic [NL-1:0] pa1, pa2, pb1, pb2;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void lane_step(input int s, input logic a, input logic b,
                                    output int ns, output logic ent, output logic ex);
    ent = 1'b0;
    ex  = 1'b0;
    ns  = s;
    case (s)
      0: if (a && !b) ns = 1; else if (!a && b) ns = 4;
      1: if (a && b) ns = 2; else if (!a && !b) ns = 0;
      2: if (!a && b) ns = 3; else if (a && !b) ns = 1; else if (!a && !b) ns = 0;
      3: if (!a && !b) begin ns = 0; ent = 1'b1; end else if (a && b) ns = 2;
      4: if (a && b) ns = 5; else if (!a && !b) ns = 0;
      5: if (a && !b) ns = 6; else if (!a && b) ns = 4; else if (!a && !b) ns = 0;
      6: if (!a && !b) begin ns = 0; ex = 1'b1; end else if (a && b) ns = 5;
      default: ns = 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_state[i] = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    pa1 = '0; pa2 = '0; pb1 = '0; pb2 = '0;
  endtask

  // Predict outputs after the coming edge and push them to the scoreboard.
  task automatic model_edge(input logic [NL-1:0] a, input logic [NL-1:0] b, input logic c);
    logic [NL-1:0] fa, fb;
    exp_t e;
    int   net, ns;
    logic en, ex;
`ifdef OCC_SYNC_EN
    fa = pa2; fb = pb2;
    pa2 = pa1; pb2 = pb1;
    pa1 = a;   pb1 = b;
`else
    fa = a; fb = b;
`endif
    net = 0;
    e.ent = '0;
    e.ex  = '0;
    for (int i = 0; i < NL; i++) begin
      lane_step(m_state[i], fa[i], fb[i], ns, en, ex);
      m_state[i] = ns;
      e.ent[i] = en;
      e.ex[i]  = ex;
      net = net + int'(en) - int'(ex);
    end
    if (c) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_cnt = m_cnt + net;
      if (m_cnt > CAP) begin m_cnt = CAP; m_ovf = 1'b1; end
      if (m_cnt < 0)   begin m_cnt = 0;   m_unf = 1'b1; end
    end
    e.cnt = m_cnt;
    e.ovf = m_ovf;
    e.unf = m_unf;
    for (int i = 0; i < NL; i++) e.dbg[3*i +: 3] = 3'(m_state[i]);
    sb_q.push_back(e);
  endtask

  // One clock: drive at negedge, predict, then compare after the edge.
  task automatic cycle(input logic [NL-1:0] a, input logic [NL-1:0] b, input logic c);
    exp_t e;
    sens_a = a;
    sens_b = b;
    clr    = c;
    model_edge(a, b, c);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("count",       int'(count),       e.cnt);
    check("full",        int'(full),        int'(e.cnt == CAP));
    check("empty",       int'(empty),       int'(e.cnt == 0));
    check("entry_pulse", int'(entry_pulse), int'(e.ent));
    check("exit_pulse",  int'(exit_pulse),  int'(e.ex));
    check("ovf_err",     int'(ovf_err),     int'(e.ovf));
    check("unf_err",     int'(unf_err),     int'(e.unf));
    check("debug_state", int'(debug_state), int'(e.dbg));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, '0, 1'b0);
  endtask

  // Full traversal on one lane: entry is A,AB,B,clear; exit is B,AB,A,clear.
  task automatic traverse(input int lane, input bit is_entry);
    logic [3:0] sa, sb;
    logic [NL-1:0] av, bv;
    sa = is_entry ? 4'b1100 : 4'b0110;
    sb = is_entry ? 4'b0110 : 4'b1100;
    for (int k = 0; k < 4; k++) begin
      av = '0;
      bv = '0;
      av[lane] = sa[3-k];
      bv[lane] = sb[3-k];
      cycle(av, bv, 1'b0);
    end
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    clr     = 1'b0;
    sens_a  = '0;
    sens_b  = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full",  int'(full),  0);
    check("rst_pulses", int'({entry_pulse, exit_pulse}), 0);
    check("rst_errs",  int'({ovf_err, unf_err}), 0);
    check("rst_state", int'(debug_state), 0);
    reset_n = 1'b1;

    // Single entry on lane 0
    traverse(0, 1'b1);
    idle(1 + SYNC_LAT);
    check("entry_count", int'(count), 1);
    check("entry_empty", int'(empty), 0);

    // Up to 3, then exit on lane 1
    traverse(0, 1'b1);
    traverse(1, 1'b1);
    idle(1 + SYNC_LAT);
    check("count_3", int'(count), 3);
    traverse(1, 1'b0);
    idle(1 + SYNC_LAT);
    check("exit_count", int'(count), 2);

    // Abort on lane 0
    cycle(2'b01, 2'b00, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
    idle(2 + SYNC_LAT);
    check("abort_count", int'(count), 2);
    check("abort_state", int'(debug_state[2:0]), 0);

    // Fill to capacity
    for (int k = 0; k < CAP - 2; k++) traverse(k % NL, 1'b1);
    idle(1 + SYNC_LAT);
    check("fill_count", int'(count), CAP);
    check("fill_full",  int'(full), 1);

    // Same-cycle entry (lane 0) and exit (lane 1) at capacity nets to zero
    cycle(2'b01, 2'b10, 1'b0);
    cycle(2'b11, 2'b11, 1'b0);
    cycle(2'b10, 2'b01, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
    idle(1 + SYNC_LAT);
    check("net_count", int'(count), CAP);
    check("net_ovf",   int'(ovf_err), 0);

    // One more entry overflows
    traverse(0, 1'b1);
    idle(1 + SYNC_LAT);
    check("ovf_count", int'(count), CAP);
    check("ovf_set",   int'(ovf_err), 1);

    // Clear, then underflow, then clear again
    cycle('0, '0, 1'b1);
    check("clr_count", int'(count), 0);
    check("clr_ovf",   int'(ovf_err), 0);
    traverse(0, 1'b0);
    idle(1 + SYNC_LAT);
    check("unf_count", int'(count), 0);
    check("unf_set",   int'(unf_err), 1);
    cycle('0, '0, 1'b1);
    check("clr_unf",   int'(unf_err), 0);

    // Latency from the final clear sample to the entry pulse
    cycle(2'b01, 2'b00, 1'b0);
    cycle(2'b01, 2'b01, 1'b0);
    cycle(2'b00, 2'b01, 1'b0);
    cycle(2'b00, 2'b00, 1'b0);
    lat = 1;
    while (!entry_pulse[0] && lat < 8) begin
      cycle('0, '0, 1'b0);
      lat++;
    end
    check("entry_latency", lat, 1 + SYNC_LAT);
    idle(2);

    // Reset asserted with lane 0 in EN_AB
    cycle(2'b01, 2'b00, 1'b0);
    cycle(2'b01, 2'b01, 1'b0);
    for (int k = 0; k < SYNC_LAT; k++) cycle(2'b01, 2'b01, 1'b0);
    check("pre_rst_state", int'(debug_state[2:0]), 2);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_state", int'(debug_state), 0);
    check("mid_rst_count", int'(count), 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    // Beams held blocked across release: stay IDLE, no events
    for (int k = 0; k < 3; k++) cycle(2'b01, 2'b01, 1'b0);
    idle(2 + SYNC_LAT);
    check("post_rst_count", int'(count), 0);
    traverse(0, 1'b1);
    idle(1 + SYNC_LAT);
    check("post_rst_entry", int'(count), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
